// File: rtl/llc_rst_flush_sequencer_pkg.sv
// llc_rst_flush_sequencer_pkg: LLC set geometry and sequencer FSM states
package llc_rst_flush_sequencer_pkg;
    localparam int LLC_SET_BITS = 2;
    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef enum logic [1:0] {IDLE, RUN, RESP} llc_rf_state_t;
endpackage

// File: rtl/llc_rst_flush_sequencer_if.sv
// llc_rst_flush_sequencer_if: command, set-issue, stall and response channels of the sequencer
interface llc_rst_flush_sequencer_if
    import llc_rst_flush_sequencer_pkg::*;
#(
    parameter int SET_BITS = LLC_SET_BITS
);
    logic                rst_tb_valid;
    logic                rst_tb_ready;
    logic                rst_tb_is_flush;
    logic                set_req_valid;
    logic                set_req_ready;
    logic                set_req_is_flush;
    logic [SET_BITS-1:0] set_idx;
    logic                set_done;
    logic                rst_stall;
    logic                flush_stall;
    logic                done_valid;
    logic                done_ready;
    logic                busy;
    logic                protocol_err;

    modport master (
        input  rst_tb_valid, rst_tb_is_flush, set_req_ready, set_done, done_ready,
        output rst_tb_ready, set_req_valid, set_req_is_flush, set_idx, rst_stall, flush_stall,
               done_valid, busy, protocol_err
    );

    modport slave (
        output rst_tb_valid, rst_tb_is_flush, set_req_ready, set_done, done_ready,
        input  rst_tb_ready, set_req_valid, set_req_is_flush, set_idx, rst_stall, flush_stall,
               done_valid, busy, protocol_err
    );
endinterface

// File: rtl/llc_rst_flush_sequencer.sv
// llc_rst_flush_sequencer: sweeps every LLC set for reset/flush with bounded outstanding sets
module llc_rst_flush_sequencer
    import llc_rst_flush_sequencer_pkg::*;
#(
    parameter int SET_BITS        = LLC_SET_BITS,
    parameter int MAX_OUTSTANDING = 1
) (
    input logic                       clk,
    input logic                       rst,
    llc_rst_flush_sequencer_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    llc_rf_state_t     state, state_n;
    logic [SET_BITS:0] issue_cnt, done_cnt;
    logic [OW-1:0]     outst;
    logic              is_flush_q;
    logic              err_q;
    logic              accept, issue, done_ok, last_done;

    assign accept    = bus.rst_tb_valid & bus.rst_tb_ready;
    assign issue     = bus.set_req_valid & bus.set_req_ready;
    assign done_ok   = bus.set_done & (outst != '0);
    // issue_cnt/done_cnt MSB means all 2**SET_BITS sets have been counted
    assign last_done = done_ok & (done_cnt == (SET_BITS+1)'((1 << SET_BITS) - 1));

    assign bus.rst_tb_ready     = (state == IDLE) & !rst;
    assign bus.set_req_valid    = (state == RUN) & !issue_cnt[SET_BITS] & (outst < OW'(MAX_OUTSTANDING));
    assign bus.set_idx          = issue_cnt[SET_BITS-1:0];
    assign bus.set_req_is_flush = is_flush_q;
    assign bus.rst_stall        = (state == RUN) & !is_flush_q;
    assign bus.flush_stall      = (state == RUN) & is_flush_q;
    assign bus.done_valid       = state == RESP;
    assign bus.busy             = state != IDLE;
    assign bus.protocol_err     = err_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? RUN : IDLE;
            RUN:     state_n = last_done ? RESP : RUN;
            RESP:    state_n = bus.done_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            done_cnt   <= '0;
            outst      <= '0;
            is_flush_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= err_q | (bus.set_done & (outst == '0));
            if (accept) begin
                issue_cnt  <= '0;
                done_cnt   <= '0;
                outst      <= '0;
                is_flush_q <= bus.rst_tb_is_flush;
            end else begin
                issue_cnt <= issue_cnt + (SET_BITS+1)'(issue);
                done_cnt  <= done_cnt + (SET_BITS+1)'(done_ok);
                outst     <= outst + OW'(issue) - OW'(done_ok);
            end
        end
    end
endmodule

// File: tb/tb_llc_rst_flush_sequencer.sv
// tb_llc_rst_flush_sequencer: directed checks on a MOUT=1 and a MOUT=2 sequencer sharing clk/rst
module tb_llc_rst_flush_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    llc_rst_flush_sequencer_if #(.SET_BITS(2)) a ();
    llc_rst_flush_sequencer_if #(.SET_BITS(2)) b ();

    llc_rst_flush_sequencer #(.SET_BITS(2), .MAX_OUTSTANDING(1)) ua (.clk(clk), .rst(rst), .bus(a));
    llc_rst_flush_sequencer #(.SET_BITS(2), .MAX_OUTSTANDING(2)) ub (.clk(clk), .rst(rst), .bus(b));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_b(input string tag);
        chk({tag, "_valid"}, int'(b.set_req_valid), 0);
        chk({tag, "_idx"}, int'(b.set_idx), 0);
        chk({tag, "_rstall"}, int'(b.rst_stall), 0);
        chk({tag, "_fstall"}, int'(b.flush_stall), 0);
        chk({tag, "_dvalid"}, int'(b.done_valid), 0);
        chk({tag, "_busy"}, int'(b.busy), 0);
        chk({tag, "_perr"}, int'(b.protocol_err), 0);
    endtask

    initial begin
        {a.rst_tb_valid, a.rst_tb_is_flush, a.set_req_ready, a.set_done, a.done_ready} = '0;
        {b.rst_tb_valid, b.rst_tb_is_flush, b.set_req_ready, b.set_done, b.done_ready} = '0;
        tick();
        tick();
        chk("rst_ready", int'(a.rst_tb_ready), 0);
        chk_idle_b("rst");
        chk("rst_fq", int'(b.set_req_is_flush), 0);
        rst = 1'b0;
        #1;
        chk("ready_idle", int'(a.rst_tb_ready), 1);

        // reset sweep, one outstanding, done two cycles after each issue
        a.rst_tb_valid  = 1'b1;
        a.set_req_ready = 1'b1;
        tick();
        a.rst_tb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_valid%0d", i), int'(a.set_req_valid), 1);
            chk($sformatf("t1_idx%0d", i), int'(a.set_idx), i);
            chk($sformatf("t1_rstall%0d", i), int'(a.rst_stall), 1);
            chk($sformatf("t1_fstall%0d", i), int'(a.flush_stall), 0);
            tick();
            chk($sformatf("t1_hold%0d", i), int'(a.set_req_valid), 0);
            tick();
            a.set_done = 1'b1;
            tick();
            a.set_done = 1'b0;
        end
        chk("t1_dvalid", int'(a.done_valid), 1);
        chk("t1_rstall_end", int'(a.rst_stall), 0);
        chk("t1_valid_end", int'(a.set_req_valid), 0);
        chk("t1_busy", int'(a.busy), 1);
        a.done_ready = 1'b1;
        tick();
        a.done_ready = 1'b0;
        chk("t1_dvalid_off", int'(a.done_valid), 0);
        chk("t1_busy_off", int'(a.busy), 0);
        chk("t1_perr_clean", int'(a.protocol_err), 0);
        a.set_done = 1'b1;
        tick();
        a.set_done = 1'b0;
        chk("perr_set", int'(a.protocol_err), 1);
        tick();
        chk("perr_sticky", int'(a.protocol_err), 1);

        // flush sweep, two outstanding, command held through the sweep
        b.rst_tb_valid    = 1'b1;
        b.rst_tb_is_flush = 1'b1;
        b.set_req_ready   = 1'b1;
        tick();
        b.rst_tb_is_flush = 1'b0;
        chk("t2_valid0", int'(b.set_req_valid), 1);
        chk("t2_idx0", int'(b.set_idx), 0);
        chk("t2_fstall", int'(b.flush_stall), 1);
        chk("t2_rstall", int'(b.rst_stall), 0);
        chk("t2_isflush", int'(b.set_req_is_flush), 1);
        chk("t5_ready_busy", int'(b.rst_tb_ready), 0);
        tick();
        chk("t2_valid1", int'(b.set_req_valid), 1);
        chk("t2_idx1", int'(b.set_idx), 1);
        tick();
        chk("t2_stop", int'(b.set_req_valid), 0);
        chk("t2_stop_idx", int'(b.set_idx), 2);
        tick();
        chk("t2_stop2", int'(b.set_req_valid), 0);
        b.set_done = 1'b1;
        tick();
        b.set_done = 1'b0;
        chk("t2_resume", int'(b.set_req_valid), 1);
        chk("t2_idx2", int'(b.set_idx), 2);
        b.set_done = 1'b1;
        tick();
        b.set_done = 1'b0;
        chk("t4_outst", int'(ub.outst), 1);
        chk("t4_idx3", int'(b.set_idx), 3);
        chk("t4_valid", int'(b.set_req_valid), 1);
        tick();
        chk("t2_last_issued", int'(b.set_req_valid), 0);
        b.set_done = 1'b1;
        tick();
        chk("t2_no_reassert", int'(b.set_req_valid), 0);
        chk("t2_fstall_run", int'(b.flush_stall), 1);
        tick();
        b.set_done = 1'b0;
        chk("t2_dvalid", int'(b.done_valid), 1);
        chk("t2_fstall_off", int'(b.flush_stall), 0);
        chk("t2_perr", int'(b.protocol_err), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_dhold%0d", i), int'(b.done_valid), 1);
            chk($sformatf("t5_rdy%0d", i), int'(b.rst_tb_ready), 0);
        end
        b.done_ready = 1'b1;
        tick();
        b.done_ready = 1'b0;
        chk("t5_idle", int'(b.busy), 0);
        chk("t5_ready_idle", int'(b.rst_tb_ready), 1);
        tick();
        b.rst_tb_valid = 1'b0;
        chk("t5_accept2", int'(b.set_req_valid), 1);
        chk("t5_idx0", int'(b.set_idx), 0);
        chk("t5_rstall", int'(b.rst_stall), 1);
        chk("t5_isflush", int'(b.set_req_is_flush), 0);

        // ready stall at idx1
        tick();
        b.set_req_ready = 1'b0;
        b.set_done      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            b.set_done = 1'b0;
            chk($sformatf("t3_valid%0d", i), int'(b.set_req_valid), 1);
            chk($sformatf("t3_idx%0d", i), int'(b.set_idx), 1);
        end
        chk("t3_cnt", int'(ub.issue_cnt), 1);
        b.set_req_ready = 1'b1;
        tick();
        chk("t3_idx2", int'(b.set_idx), 2);
        chk("t3_valid2", int'(b.set_req_valid), 1);
        chk("t6_perr_a_pre", int'(a.protocol_err), 1);

        // sync reset mid-sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_b("t6");
        chk("t6_perr_a", int'(a.protocol_err), 0);
        b.set_done = 1'b1;
        tick();
        b.set_done = 1'b0;
        chk("t6_late_done", int'(b.protocol_err), 1);
        b.rst_tb_valid = 1'b1;
        tick();
        b.rst_tb_valid = 1'b0;
        chk("t6_restart_valid", int'(b.set_req_valid), 1);
        chk("t6_restart_idx", int'(b.set_idx), 0);
        chk("t6_restart_rstall", int'(b.rst_stall), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
